// File: rtl/fir_tf_cfg_if.sv
// Sample stream interface for fir_tf_cfg: input side (data_in/in_valid/in_ready)
// and output side (data_out/out_valid/out_ready), both valid/ready handshakes.
// The slave modport is the filter's view; the master modport is the source/consumer view.
interface fir_tf_cfg_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 12
);
    logic signed [IN_W-1:0]  data_in;
    logic                    in_valid;
    logic                    in_ready;
    logic        [OUT_W-1:0] data_out;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output data_in,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  data_out,
        input  out_valid
    );

    modport slave (
        input  data_in,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output data_out,
        output out_valid
    );
endinterface

// File: rtl/fir_tf_cfg.sv
// Transposed-form FIR filter with runtime-loadable coefficients, per-tap product
// fractional truncation, valid/ready flow control and a one-entry output register.
// Optional feature macro: FIR_SAT_EN -- when defined the output slice saturates and
// a sticky sat_flag is kept; when undefined the output slice wraps and sat_flag is 0.
module fir_tf_cfg #(
    parameter int N_TAPS      = 15,
    parameter int COE_INTE_WL = 4,
    parameter int COE_FRAC_WL = 8,
    parameter int IN_INTE_WL  = 4,
    parameter int IN_FRAC_WL  = 8,
    parameter int OUT_INTE_WL = 4,
    parameter int OUT_FRAC_WL = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clr,
    input  logic                                   coef_we,
    input  logic [$clog2(N_TAPS)-1:0]              coef_addr,
    input  logic [COE_INTE_WL+COE_FRAC_WL-1:0]     coef_data,
    input  logic [8*N_TAPS-1:0]                    frac_wl,
    fir_tf_cfg_if.slave                            strm,
    output logic                                   sat_flag
);

    localparam int CW   = COE_INTE_WL + COE_FRAC_WL;
    localparam int OW   = OUT_INTE_WL + OUT_FRAC_WL;
    localparam int PI   = COE_INTE_WL + IN_INTE_WL;
    localparam int PF   = COE_FRAC_WL + IN_FRAC_WL;
    localparam int PW   = PI + PF;
    localparam int GW   = $clog2(N_TAPS);
    localparam int AW   = PW + GW;
    // MSB of the output slice inside the accumulator word
    localparam int Y_HI = PF + OUT_INTE_WL - 1;

    logic [CW-1:0]             coef_q [N_TAPS];
    logic [AW-1:0]             s_q    [N_TAPS-1];
    logic [AW-1:0]             s_d    [N_TAPS-1];
    logic [N_TAPS-1:0][AW-1:0] pe;
    logic [AW-1:0]             y;
    logic [OW-1:0]             y_wrap;
    logic [OW-1:0]             out_d;
    logic [OW-1:0]             data_out_q;
    logic                      out_valid_q;
    logic                      in_ready;
    logic                      acc;
    logic                      unused_y;

    // Output register is a single entry: room exists when empty or being popped now.
    assign in_ready       = !out_valid_q || strm.out_ready;
    assign strm.in_ready  = in_ready;
    // A sample taken during clr is discarded, so it must not advance the pipeline.
    assign acc            = strm.in_valid && in_ready && !clr;
    assign strm.data_out  = data_out_q;
    assign strm.out_valid = out_valid_q;

    // Per-tap product, fractional truncation and sign extension into the accumulator width
    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
        logic [PW-1:0] p_full;
        logic [PW-1:0] p_trunc;
        logic [PW-1:0] keep_mask;

        assign p_full = PW'($signed(coef_q[gi])) * PW'(strm.data_in);

        // Zero the lowest PF-k fraction bits, k = min(frac_wl[gi], PF); masking the
        // low bits of a two's-complement value truncates toward minus infinity.
        always_comb begin : mask_comb
            int k;
            k = int'(frac_wl[8*gi +: 8]);
            if (k > PF) begin
                k = PF;
            end
            keep_mask = '1;
            for (int j = 0; j < PF; j++) begin
                if (j < PF - k) begin
                    keep_mask[j] = 1'b0;
                end
            end
        end

        assign p_trunc = p_full & keep_mask;
        assign pe[gi]  = {{GW{p_trunc[PW-1]}}, p_trunc};
    end

    // Transposed delay line: each partial sum picks up the next tap's product
    always_comb begin
        for (int i = 0; i < N_TAPS - 2; i++) begin
            s_d[i] = pe[i+1] + s_q[i+1];
        end
        s_d[N_TAPS-2] = pe[N_TAPS-1];
    end

    // Filter output uses the partial sums from before this update
    assign y        = pe[0] + s_q[0];
    assign y_wrap   = y[Y_HI -: OW];
    assign unused_y = ^y;

`ifdef FIR_SAT_EN
    logic [AW-Y_HI-1:0] y_top;
    logic               ovf;
    logic               sat_q;

    // Overflow when the bits above the kept sign bit are not a pure sign extension
    assign y_top    = y[AW-1:Y_HI];
    assign ovf      = !((&y_top) || !(|y_top));
    assign out_d    = !ovf       ? y_wrap :
                      y[AW-1]    ? {1'b1, {(OW-1){1'b0}}} :
                                   {1'b0, {(OW-1){1'b1}}};
    assign sat_flag = sat_q;

    // Sticky overflow indicator, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (acc && ovf) begin
            sat_q <= 1'b1;
        end
    end
`else
    assign out_d    = y_wrap;
    assign sat_flag = 1'b0;
`endif

    // Coefficient bank; writes outside the tap range match no entry and are dropped.
    // clr does not touch the coefficients.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else if (coef_we) begin
            for (int i = 0; i < N_TAPS; i++) begin
                if (coef_addr == GW'(i)) begin
                    coef_q[i] <= coef_data;
                end
            end
        end
    end

    // Pipeline state: partial sums and the output register with its valid bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS - 1; i++) begin
                s_q[i] <= '0;
            end
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < N_TAPS - 1; i++) begin
                s_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
        end else if (acc) begin
            for (int i = 0; i < N_TAPS - 1; i++) begin
                s_q[i] <= s_d[i];
            end
            data_out_q  <= out_d;
            out_valid_q <= 1'b1;
        end else if (strm.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule
